enemy_layer: RTL and testbench

- Per-enemy pixel source feeding the layer compositor; one instance per enemy slot (enemy0..enemy2).
- Owns the enemy's position and life cycle: spawn, descend, explode on hit, cool down, respawn.
- Walks the VGA raster (h_cnt/v_cnt) and emits the sprite colour, or 12'h000 (transparent) where the enemy is not drawn.
- Raises a one-cycle breach pulse when the enemy reaches the bottom; the game FSM uses it to enter FAILURE.

---
 rtl/enemy_layer.sv | 198 +++++++++++++++++++
 tb/tb_enemy_layer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/enemy_layer.sv
// enemy_layer: per-enemy sprite source owning spawn, descent, explosion and cooldown of one enemy slot.
// Optional build macro ENEMY_OUTLINE_EN draws a 12'hFFF one-pixel outline around the live sprite.
module enemy_layer #(
    parameter int          SPRITE_W       = 32,
    parameter int          SPRITE_H       = 32,
    parameter int          SCREEN_W       = 640,
    parameter int          SCREEN_H       = 480,
    parameter logic [11:0] COLOR          = 12'hF00,
    parameter logic [11:0] BOOM_COLOR     = 12'hFF0,
    parameter int          BOOM_FRAMES    = 8,
    parameter int          RESPAWN_FRAMES = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  state,
    input  logic [9:0]  h_cnt,
    input  logic [9:0]  v_cnt,
    input  logic        valid,
    input  logic        frame_tick,
    input  logic [9:0]  spawn_x,
    input  logic        hit,
    output logic [11:0] pixel,
    output logic        alive,
    output logic        breach
);

    localparam int CNT_MAX = (BOOM_FRAMES > RESPAWN_FRAMES) ? BOOM_FRAMES : RESPAWN_FRAMES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [10:0]      SW_L      = 11'(SPRITE_W);
    localparam logic [10:0]      SH_L      = 11'(SPRITE_H);
    localparam logic [10:0]      XMAX_L    = 11'(SCREEN_W - SPRITE_W);
    localparam logic [10:0]      YLIM_L    = 11'(SCREEN_H - SPRITE_H);
    localparam logic [CNT_W-1:0] BOOM_END  = CNT_W'(BOOM_FRAMES - 1);
    localparam logic [CNT_W-1:0] COOL_END  = CNT_W'(RESPAWN_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACTIVE   = 2'd1,
        ST_EXPLODE  = 2'd2,
        ST_COOLDOWN = 2'd3
    } fsm_t;

    fsm_t             fsm_r;
    logic [9:0]       pos_x_r;
    logic [9:0]       pos_y_r;
    logic [CNT_W-1:0] cnt_r;
    logic [11:0]      pixel_r;
    logic             alive_r;
    logic             breach_r;

    logic             game_ok_s;
    logic [10:0]      speed_s;
    logic [10:0]      h11_s;
    logic [10:0]      v11_s;
    logic [10:0]      px11_s;
    logic [10:0]      py11_s;
    logic [10:0]      y_next_s;
    logic [9:0]       spawn_clamp_s;
    logic             in_box_s;
    logic             edge_s;
    logic [11:0]      active_color_s;
    logic [11:0]      pixel_nxt_s;

    // All box and descent arithmetic is widened to 11 bits so pos+size never wraps.
    assign game_ok_s     = (state >= 4'd1) && (state <= 4'd4);
    assign h11_s         = {1'b0, h_cnt};
    assign v11_s         = {1'b0, v_cnt};
    assign px11_s        = {1'b0, pos_x_r};
    assign py11_s        = {1'b0, pos_y_r};
    assign y_next_s      = py11_s + speed_s;
    assign spawn_clamp_s = ({1'b0, spawn_x} > XMAX_L) ? XMAX_L[9:0] : spawn_x;
    assign in_box_s      = (h11_s >= px11_s) && (h11_s < px11_s + SW_L) &&
                           (v11_s >= py11_s) && (v11_s < py11_s + SH_L);
    assign edge_s        = (h11_s == px11_s) || (h11_s == px11_s + SW_L - 11'd1) ||
                           (v11_s == py11_s) || (v11_s == py11_s + SH_L - 11'd1);

    // Descent speed in pixels per frame for each playable difficulty.
    always_comb begin
        speed_s = 11'd0;
        case (state)
            4'd1:    speed_s = 11'd1;
            4'd2:    speed_s = 11'd2;
            4'd3:    speed_s = 11'd3;
            4'd4:    speed_s = 11'd4;
            default: speed_s = 11'd0;
        endcase
    end

    // Colour of a live-sprite pixel, optionally with a white border.
    always_comb begin
        active_color_s = COLOR;
`ifdef ENEMY_OUTLINE_EN
        if (edge_s) begin
            active_color_s = 12'hFFF;
        end else begin
            active_color_s = COLOR;
        end
`else
        if (edge_s) begin
            active_color_s = COLOR;
        end else begin
            active_color_s = COLOR;
        end
`endif
    end

    // Next pixel; an invalid game state blanks the layer on the same edge the FSM drops to IDLE.
    always_comb begin
        pixel_nxt_s = 12'h000;
        if (game_ok_s && valid && in_box_s) begin
            case (fsm_r)
                ST_ACTIVE:  pixel_nxt_s = active_color_s;
                ST_EXPLODE: pixel_nxt_s = cnt_r[0] ? 12'h000 : BOOM_COLOR;
                default:    pixel_nxt_s = 12'h000;
            endcase
        end else begin
            pixel_nxt_s = 12'h000;
        end
    end

    // Life-cycle FSM with registered pixel, alive and breach outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_r    <= ST_IDLE;
            pos_x_r  <= 10'd0;
            pos_y_r  <= 10'd0;
            cnt_r    <= '0;
            pixel_r  <= 12'h000;
            alive_r  <= 1'b0;
            breach_r <= 1'b0;
        end else begin
            pixel_r  <= pixel_nxt_s;
            breach_r <= 1'b0;
            if (!game_ok_s) begin
                fsm_r   <= ST_IDLE;
                cnt_r   <= '0;
                alive_r <= 1'b0;
            end else begin
                case (fsm_r)
                    ST_IDLE: begin
                        if (frame_tick) begin
                            fsm_r   <= ST_ACTIVE;
                            pos_x_r <= spawn_clamp_s;
                            pos_y_r <= 10'd0;
                            alive_r <= 1'b1;
                        end
                    end
                    ST_ACTIVE: begin
                        if (hit) begin
                            fsm_r   <= ST_EXPLODE;
                            cnt_r   <= '0;
                            alive_r <= 1'b0;
                        end else if (frame_tick) begin
                            if (y_next_s >= YLIM_L) begin
                                fsm_r    <= ST_IDLE;
                                breach_r <= 1'b1;
                                alive_r  <= 1'b0;
                            end else begin
                                pos_y_r <= y_next_s[9:0];
                            end
                        end
                    end
                    ST_EXPLODE: begin
                        if (frame_tick) begin
                            if (cnt_r == BOOM_END) begin
                                fsm_r <= ST_COOLDOWN;
                                cnt_r <= '0;
                            end else begin
                                cnt_r <= cnt_r + CNT_W'(1);
                            end
                        end
                    end
                    ST_COOLDOWN: begin
                        if (frame_tick) begin
                            if (cnt_r == COOL_END) begin
                                fsm_r <= ST_IDLE;
                                cnt_r <= '0;
                            end else begin
                                cnt_r <= cnt_r + CNT_W'(1);
                            end
                        end
                    end
                    default: begin
                        fsm_r   <= ST_IDLE;
                        cnt_r   <= '0;
                        alive_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign pixel  = pixel_r;
    assign alive  = alive_r;
    assign breach = breach_r;

endmodule

// File: tb/tb_enemy_layer.sv
// Testbench for enemy_layer: directed scenarios plus randomized traffic against a frame-level behavioural model.
module tb_enemy_layer;

`ifdef ENEMY_OUTLINE_EN
    localparam bit OUTLINE = 1'b1;
`else
    localparam bit OUTLINE = 1'b0;
`endif
    localparam int M_IDLE = 0, M_ACT = 1, M_EXP = 2, M_COOL = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  state = 4'd0;
    logic [9:0]  h_cnt = 10'd0;
    logic [9:0]  v_cnt = 10'd0;
    logic        valid = 1'b0;
    logic        frame_tick = 1'b0;
    logic [9:0]  spawn_x = 10'd0;
    logic        hit = 1'b0;
    logic [11:0] pixel;
    logic        alive;
    logic        breach;

    int vec = 0;
    int fails = 0;

    // Behavioural model: life-cycle mode, sprite origin and frame count.
    int m_mode = M_IDLE, m_x = 0, m_y = 0, m_cnt = 0;
    int m_pix = 0, m_alive = 0, m_breach = 0;

    enemy_layer dut (
        .clk(clk), .rst(rst), .state(state), .h_cnt(h_cnt), .v_cnt(v_cnt),
        .valid(valid), .frame_tick(frame_tick), .spawn_x(spawn_x), .hit(hit),
        .pixel(pixel), .alive(alive), .breach(breach)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        m_mode = M_IDLE; m_x = 0; m_y = 0; m_cnt = 0;
        m_pix = 0; m_alive = 0; m_breach = 0;
    endtask

    // One clock: drive inputs, advance the model by the rules, settle 1 time unit after the edge.
    task automatic step(input int st, input int h, input int v, input bit val,
                        input bit ft, input int sx, input bit ht);
        bit ok, inb, edg;
        state = st[3:0]; h_cnt = h[9:0]; v_cnt = v[9:0]; valid = val;
        frame_tick = ft; spawn_x = sx[9:0]; hit = ht;
        @(posedge clk);
        if (!rst) begin
            model_clear();
        end else begin
            ok  = (st >= 1) && (st <= 4);
            inb = val && (h >= m_x) && (h < m_x + 32) && (v >= m_y) && (v < m_y + 32);
            edg = (h == m_x) || (h == m_x + 31) || (v == m_y) || (v == m_y + 31);
            m_pix = 0;
            if (ok && inb && m_mode == M_ACT) m_pix = (OUTLINE && edg) ? 'hFFF : 'hF00;
            if (ok && inb && m_mode == M_EXP && (m_cnt % 2) == 0) m_pix = 'hFF0;
            m_breach = 0;
            if (!ok) begin
                m_mode = M_IDLE; m_cnt = 0;
            end else if (m_mode == M_IDLE) begin
                if (ft) begin m_mode = M_ACT; m_x = (sx > 608) ? 608 : sx; m_y = 0; end
            end else if (m_mode == M_ACT) begin
                if (ht) begin m_mode = M_EXP; m_cnt = 0; end
                else if (ft) begin
                    if (m_y + st >= 448) begin m_breach = 1; m_mode = M_IDLE; end
                    else m_y = m_y + st;
                end
            end else if (m_mode == M_EXP) begin
                if (ft) begin
                    if (m_cnt == 7) begin m_mode = M_COOL; m_cnt = 0; end else m_cnt++;
                end
            end else begin
                if (ft) begin
                    if (m_cnt == 59) begin m_mode = M_IDLE; m_cnt = 0; end else m_cnt++;
                end
            end
            m_alive = (m_mode == M_ACT);
        end
        #1;
    endtask

    task automatic tick(input int st);
        step(st, 0, 0, 0, 1, 0, 0);
    endtask

    task automatic probe(input int st, input int h, input int v);
        step(st, h, v, 1, 0, 0, 0);
    endtask

    task automatic spawn(input int st, input int sx);
        step(0, 0, 0, 0, 0, 0, 0);
        step(st, 0, 0, 0, 1, sx, 0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step(1, 100, 0, 1, 1, 100, 0);
        step(1, 100, 0, 1, 1, 100, 1);
        vec++; if (pixel !== 12'h000) begin fails++; $display("FAIL reset_pixel got=%h exp=000", pixel); end
        vec++; if (alive !== 1'b0) begin fails++; $display("FAIL reset_alive got=%b exp=0", alive); end
        vec++; if (breach !== 1'b0) begin fails++; $display("FAIL reset_breach got=%b exp=0", breach); end
        rst = 1'b1;
    endtask

    task automatic test_spawn();
        logic [11:0] exp_edge;
        exp_edge = OUTLINE ? 12'hFFF : 12'hF00;
        step(1, 0, 0, 0, 1, 100, 0);
        vec++; if (alive !== 1'b1) begin fails++; $display("FAIL spawn_alive got=%b exp=1", alive); end
        probe(1, 100, 0);
        vec++; if (pixel !== exp_edge) begin fails++; $display("FAIL spawn_px100 got=%h exp=%h", pixel, exp_edge); end
        probe(1, 132, 0);
        vec++; if (pixel !== 12'h000) begin fails++; $display("FAIL spawn_px132 got=%h exp=000", pixel); end
        probe(1, 99, 0);
        vec++; if (pixel !== 12'h000) begin fails++; $display("FAIL spawn_px99 got=%h exp=000", pixel); end
        probe(1, 110, 10);
        vec++; if (pixel !== 12'hF00) begin fails++; $display("FAIL spawn_interior got=%h exp=F00", pixel); end
    endtask

    task automatic test_descent();
        int early;
        spawn(4, 200);
        early = 0;
        for (int i = 0; i < 111; i++) begin
            tick(4);
            if (breach !== 1'b0) early++;
            step(4, 0, 0, 0, 0, 0, 0);
        end
        vec++; if (early != 0) begin fails++; $display("FAIL descent4_early got=%0d breaches exp=0", early); end
        probe(4, 205, 450);
        vec++; if (pixel !== 12'hF00) begin fails++; $display("FAIL descent4_y444 got=%h exp=F00", pixel); end
        probe(4, 205, 443);
        vec++; if (pixel !== 12'h000) begin fails++; $display("FAIL descent4_y443 got=%h exp=000", pixel); end
        tick(4);
        vec++; if (breach !== 1'b1) begin fails++; $display("FAIL descent4_breach got=%b exp=1", breach); end
        vec++; if (alive !== 1'b0) begin fails++; $display("FAIL descent4_alive got=%b exp=0", alive); end
        probe(4, 205, 450);
        vec++; if (breach !== 1'b0) begin fails++; $display("FAIL descent4_pulse got=%b exp=0", breach); end
        vec++; if (pixel !== 12'h000) begin fails++; $display("FAIL descent4_px got=%h exp=000", pixel); end

        spawn(1, 40);
        early = 0;
        for (int i = 0; i < 447; i++) begin
            tick(1);
            if (breach !== 1'b0) early++;
        end
        vec++; if (early != 0) begin fails++; $display("FAIL descent1_early got=%0d breaches exp=0", early); end
        tick(1);
        vec++; if (breach !== 1'b1) begin fails++; $display("FAIL descent1_breach got=%b exp=1", breach); end
        step(1, 0, 0, 0, 0, 0, 0);
        vec++; if (breach !== 1'b0) begin fails++; $display("FAIL descent1_pulse got=%b exp=0", breach); end
    endtask

    task automatic test_hit();
        logic [11:0] exp;
        spawn(2, 200);
        tick(2); tick(2);
        step(2, 0, 0, 0, 0, 0, 1);
        vec++; if (alive !== 1'b0) begin fails++; $display("FAIL hit_alive got=%b exp=0", alive); end
        for (int k = 0; k < 8; k++) begin
            if (k == 3) step(2, 0, 0, 0, 0, 0, 1);
            probe(2, 210, 15);
            exp = (k % 2 == 0) ? 12'hFF0 : 12'h000;
            vec++; if (pixel !== exp) begin fails++; $display("FAIL hit_flash%0d got=%h exp=%h", k, pixel, exp); end
            tick(2);
        end
        probe(2, 210, 15);
        vec++; if (pixel !== 12'h000) begin fails++; $display("FAIL cool_px got=%h exp=000", pixel); end
        step(2, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 59; k++) tick(2);
        vec++; if (alive !== 1'b0) begin fails++; $display("FAIL cool59_alive got=%b exp=0", alive); end
        tick(2);
        vec++; if (alive !== 1'b0) begin fails++; $display("FAIL cool60_alive got=%b exp=0", alive); end
        step(2, 0, 0, 0, 1, 300, 0);
        vec++; if (alive !== 1'b1) begin fails++; $display("FAIL respawn_alive got=%b exp=1", alive); end
        probe(2, 310, 10);
        vec++; if (pixel !== 12'hF00) begin fails++; $display("FAIL respawn_px got=%h exp=F00", pixel); end
    endtask

    task automatic test_simultaneous();
        spawn(4, 300);
        for (int i = 0; i < 111; i++) tick(4);
        step(4, 0, 0, 0, 1, 0, 1);
        vec++; if (breach !== 1'b0) begin fails++; $display("FAIL simul_breach got=%b exp=0", breach); end
        vec++; if (alive !== 1'b0) begin fails++; $display("FAIL simul_alive got=%b exp=0", alive); end
        probe(4, 310, 455);
        vec++; if (pixel !== 12'hFF0) begin fails++; $display("FAIL simul_explode got=%h exp=FF0", pixel); end
        spawn(1, 700);
        probe(1, 607, 10);
        vec++; if (pixel !== 12'h000) begin fails++; $display("FAIL clamp_607 got=%h exp=000", pixel); end
        probe(1, 609, 10);
        vec++; if (pixel !== 12'hF00) begin fails++; $display("FAIL clamp_609 got=%h exp=F00", pixel); end
    endtask

    task automatic test_abort();
        spawn(3, 50);
        tick(3); tick(3);
        step(5, 55, 10, 1, 0, 0, 0);
        vec++; if (alive !== 1'b0) begin fails++; $display("FAIL abort_alive got=%b exp=0", alive); end
        vec++; if (pixel !== 12'h000) begin fails++; $display("FAIL abort_px got=%h exp=000", pixel); end
        vec++; if (breach !== 1'b0) begin fails++; $display("FAIL abort_breach got=%b exp=0", breach); end
        probe(3, 55, 10);
        vec++; if (pixel !== 12'h000) begin fails++; $display("FAIL abort_idle_px got=%h exp=000", pixel); end
        spawn(3, 50);
        step(3, 0, 0, 0, 0, 0, 1);
        probe(3, 55, 10);
        vec++; if (pixel !== 12'hFF0) begin fails++; $display("FAIL preboom_px got=%h exp=FF0", pixel); end
        rst = 1'b0;
        #1;
        vec++; if (pixel !== 12'h000) begin fails++; $display("FAIL rst_boom_px got=%h exp=000", pixel); end
        step(3, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        probe(3, 55, 10);
        vec++; if (pixel !== 12'h000) begin fails++; $display("FAIL rst_idle_px got=%h exp=000", pixel); end
        step(3, 0, 0, 0, 1, 50, 0);
        vec++; if (alive !== 1'b1) begin fails++; $display("FAIL rst_respawn got=%b exp=1", alive); end
    endtask

    task automatic test_outline();
        logic [11:0] exp_edge;
        exp_edge = OUTLINE ? 12'hFFF : 12'hF00;
        spawn(1, 100);
        probe(1, 100, 10);
        vec++; if (pixel !== exp_edge) begin fails++; $display("FAIL outline_left got=%h exp=%h", pixel, exp_edge); end
        probe(1, 131, 10);
        vec++; if (pixel !== exp_edge) begin fails++; $display("FAIL outline_right got=%h exp=%h", pixel, exp_edge); end
        probe(1, 110, 31);
        vec++; if (pixel !== exp_edge) begin fails++; $display("FAIL outline_bottom got=%h exp=%h", pixel, exp_edge); end
        probe(1, 110, 10);
        vec++; if (pixel !== 12'hF00) begin fails++; $display("FAIL outline_inner got=%h exp=F00", pixel); end
    endtask

    task automatic test_random();
        int st, h, v, sx;
        bit ft, ht, val;
        for (int n = 0; n < 3000; n++) begin
            st  = ($urandom_range(0, 99) < 3) ? int'($urandom_range(0, 15)) : int'($urandom_range(1, 4));
            ft  = ($urandom_range(0, 3) == 0);
            ht  = ($urandom_range(0, 39) == 0);
            val = ($urandom_range(0, 7) != 0);
            h   = m_x + int'($urandom_range(0, 40)) - 4;
            v   = m_y + int'($urandom_range(0, 40)) - 4;
            if (h < 0) h = 0;
            if (v < 0) v = 0;
            sx  = int'($urandom_range(0, 1023));
            step(st, h, v, val, ft, sx, ht);
            vec++; if (pixel !== m_pix[11:0]) begin fails++; $display("FAIL rand_pixel n=%0d got=%h exp=%h", n, pixel, m_pix[11:0]); end
            vec++; if (alive !== m_alive[0]) begin fails++; $display("FAIL rand_alive n=%0d got=%b exp=%0d", n, alive, m_alive); end
            vec++; if (breach !== m_breach[0]) begin fails++; $display("FAIL rand_breach n=%0d got=%b exp=%0d", n, breach, m_breach); end
        end
    endtask

    initial begin
        test_reset();
        test_spawn();
        test_descent();
        test_hit();
        test_simultaneous();
        test_abort();
        test_outline();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, fails);
        $finish;
    end

endmodule
